// File: rtl/mmio_responder_if.sv
// mmio_responder_if: D-memory bus slice and TX drain stream seen by mmio_responder.
// The core/bench side uses the master modport and the responder uses the slave modport.
interface mmio_responder_if;
  logic        CSN;
  logic        WEN;
  logic [3:0]  BE;
  logic [11:0] ADDR;
  logic [31:0] DI;
  logic [31:0] DOUT;
  logic        HIT;
  logic        TX_VALID;
  logic [31:0] TX_DATA;
  logic        TX_READY;

  modport master (
    output CSN, WEN, BE, ADDR, DI, TX_READY,
    input  DOUT, HIT, TX_VALID, TX_DATA
  );

  modport slave (
    input  CSN, WEN, BE, ADDR, DI, TX_READY,
    output DOUT, HIT, TX_VALID, TX_DATA
  );
endinterface

// File: rtl/mmio_responder.sv
// mmio_responder: MMIO window beside the data SRAM.
// It provides a TX push FIFO with a valid/ready drain, STATUS/flush, a CYCLE counter,
// and a sticky HALT.
// Define MMIO_CYCLE_EN to build the CYCLE counter. Without it, CYCLE reads return 0
// and CYCLE writes are ignored.
module mmio_responder #(
  parameter logic [7:0] BASE_ADDR  = 8'hFF,
  parameter int         FIFO_DEPTH = 8,
  parameter int         CNT_W      = 4
) (
  input  logic             CLK,
  input  logic             RST,
  mmio_responder_if.slave  bus,
  output logic             HALT,
  output logic [CNT_W-1:0] FIFO_CNT
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_STATUS = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_HALT   = 2'd3
  } reg_off_e;

  // Bus decode
  logic     sel;
  logic     wr;
  logic     rd;
  reg_off_e off;
  logic     unused_addr_lsb;

  assign sel = ~bus.CSN & (bus.ADDR[11:4] == BASE_ADDR);
  assign wr  = sel & ~bus.WEN;
  assign rd  = sel &  bus.WEN;
  assign off = reg_off_e'(bus.ADDR[3:2]);
  // The window is word-addressed, so the byte offset bits are not used.
  assign unused_addr_lsb = ^bus.ADDR[1:0];

  // TX FIFO control
  logic [31:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push_req;
  logic             push_ok;
  logic             ovf_set;
  logic             flush;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_W'(FIFO_DEPTH));
  assign pop      = ~empty & bus.TX_READY;
  assign push_req = wr & (off == REG_TXDATA) & (bus.BE == 4'hF);
  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign push_ok  = push_req & (~full | pop);
  assign ovf_set  = push_req & full & ~pop;
  assign flush    = wr & (off == REG_STATUS) & bus.BE[0] & bus.DI[0];

  // Pointer, occupancy and overflow state. A flush wins over any pop on the same edge.
  // NOTE: every clocked block uses non-blocking assignments, so all registers see pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop);
      if (ovf_set) ovf <= 1'b1;
    end
  end

  // FIFO storage write
  // NOTE: storage is deliberately not reset. TX_DATA is masked while empty, so stale entries never escape.
  always_ff @(posedge CLK) begin
    if (push_ok) mem[wr_ptr] <= bus.DI;
  end

  assign bus.TX_VALID = ~empty;
  assign bus.TX_DATA  = empty ? 32'h0 : mem[rd_ptr];
  assign FIFO_CNT     = cnt;

  // Cycle counter
  logic [31:0] cycle_q;
`ifdef MMIO_CYCLE_EN
  logic cyc_wr;
  assign cyc_wr = wr & (off == REG_CYCLE);

  // A write loads the counter byte-wise and replaces that cycle's increment.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cycle_q <= '0;
    end else if (cyc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.BE[i]) cycle_q[8*i +: 8] <= bus.DI[8*i +: 8];
      end
    end else begin
      cycle_q <= cycle_q + 32'd1;
    end
  end
`else
  assign cycle_q = 32'h0;
`endif

  // Sticky halt request, cleared only by reset
  logic halt_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      halt_q <= 1'b0;
    end else if (wr & (off == REG_HALT) & bus.BE[0] & bus.DI[0]) begin
      halt_q <= 1'b1;
    end
  end
  assign HALT = halt_q;

  // Read data selection from pre-edge register state
  // NOTE: rdata is defaulted before the case, so no path leaves it unassigned and no latch is inferred.
  logic [31:0] rdata;
  always_comb begin
    rdata = 32'h0;
    case (off)
      REG_TXDATA: rdata = 32'h0;
      REG_STATUS: rdata = {16'h0, 8'(cnt), 5'b0, ovf, full, empty};
      REG_CYCLE:  rdata = cycle_q;
      REG_HALT:   rdata = {31'h0, halt_q};
      default:    rdata = 32'h0;
    endcase
  end

  // Registered read port: one-cycle latency like the SRAM, with DOUT held between reads
  logic [31:0] dout_q;
  logic        hit_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dout_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      hit_q <= rd;
      if (rd) dout_q <= rdata;
    end
  end

  assign bus.DOUT = dout_q;
  assign bus.HIT  = hit_q;

endmodule

// File: tb/tb_mmio_responder.sv
// tb_mmio_responder: directed steps followed by randomized bus/stream traffic.
// Each step is checked against a queue-based reference of the register map.
module tb_mmio_responder;
  localparam int         DEPTH = 8;
  localparam logic [7:0] BASE  = 8'hFF;

  logic       CLK = 1'b0;
  logic       RST;
  logic       HALT;
  logic [3:0] FIFO_CNT;

  mmio_responder_if bus ();

  mmio_responder #(.BASE_ADDR(BASE), .FIFO_DEPTH(DEPTH), .CNT_W(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .bus      (bus),
    .HALT     (HALT),
    .FIFO_CNT (FIFO_CNT)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  logic [31:0] q[$];
  logic        m_ovf;
  logic        m_halt;
  logic [31:0] m_dout;
  logic [31:0] cyc_base;
  int unsigned cyc_edge;
  int unsigned n_edges;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Counter value after n_edges rising edges: last loaded value plus edges since the load
  function automatic logic [31:0] cycle_now();
    return cyc_base + 32'(n_edges - cyc_edge);
  endfunction

  // One bus cycle: drive, predict, clock, compare
  task automatic step(input logic csn, input logic wen, input logic [3:0] be,
                      input logic [11:0] addr, input logic [31:0] di, input logic ready);
    logic        in_win, wr_x, rd_x, popped;
    logic [1:0]  off;
    logic [31:0] rd_data, cyc_pre, cyc_new;
    bus.CSN = csn; bus.WEN = wen; bus.BE = be; bus.ADDR = addr; bus.DI = di; bus.TX_READY = ready;
    in_win  = !csn && (addr[11:4] == BASE);
    wr_x    = in_win && !wen;
    rd_x    = in_win && wen;
    off     = addr[3:2];
    cyc_pre = cycle_now();
    case (off)
      2'd0: rd_data = 32'h0;
      2'd1: rd_data = {16'h0, 8'(q.size()), 5'h0, m_ovf, q.size() == DEPTH, q.size() == 0};
`ifdef MMIO_CYCLE_EN
      2'd2: rd_data = cyc_pre;
`else
      2'd2: rd_data = 32'h0;
`endif
      default: rd_data = {31'h0, m_halt};
    endcase
    @(posedge CLK);
    n_edges++;
    popped = (q.size() != 0) && ready;
    if (popped) void'(q.pop_front());
    if (wr_x) begin
      case (off)
        2'd0: if (be == 4'hF) begin
          if (q.size() < DEPTH) q.push_back(di);
          else m_ovf = 1'b1;
        end
        2'd1: if (be[0] && di[0]) begin
          q.delete();
          m_ovf = 1'b0;
        end
        2'd2: begin
          cyc_new = cyc_pre;
          for (int b = 0; b < 4; b++) if (be[b]) cyc_new[8*b +: 8] = di[8*b +: 8];
          cyc_base = cyc_new;
          cyc_edge = n_edges;
        end
        default: if (be[0] && di[0]) m_halt = 1'b1;
      endcase
    end
    if (rd_x) m_dout = rd_data;
    #1;
    check("hit",      32'(bus.HIT),      32'(rd_x));
    check("dout",     bus.DOUT,          m_dout);
    check("tx_valid", 32'(bus.TX_VALID), 32'(q.size() != 0));
    check("tx_data",  bus.TX_DATA,       (q.size() != 0) ? q[0] : 32'h0);
    check("fifo_cnt", 32'(FIFO_CNT),     32'(q.size()));
    check("halt",     32'(HALT),         32'(m_halt));
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be, input logic ready);
    step(1'b0, 1'b0, be, a, d, ready);
  endtask

  task automatic rd(input logic [11:0] a, input logic ready);
    step(1'b0, 1'b1, 4'hF, a, 32'h0, ready);
  endtask

  task automatic idle(input logic ready);
    step(1'b1, 1'b1, 4'h0, 12'h000, 32'h0, ready);
  endtask

  // Assert reset between edges, confirm outputs clear without a clock, then release
  task automatic apply_reset(input string tag);
    RST = 1'b1;
    #1;
    check({tag, "_dout"},     bus.DOUT,          32'h0);
    check({tag, "_hit"},      32'(bus.HIT),      32'h0);
    check({tag, "_tx_valid"}, 32'(bus.TX_VALID), 32'h0);
    check({tag, "_tx_data"},  bus.TX_DATA,       32'h0);
    check({tag, "_halt"},     32'(HALT),         32'h0);
    check({tag, "_fifo_cnt"}, 32'(FIFO_CNT),     32'h0);
    @(posedge CLK);
    @(posedge CLK);
    #3 RST = 1'b0;
    q.delete();
    m_ovf    = 1'b0;
    m_halt   = 1'b0;
    m_dout   = 32'h0;
    cyc_base = 32'h0;
    cyc_edge = n_edges;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [11:0] a;
    logic [3:0]  be;
    logic [31:0] di;
    logic [1:0]  off;
    logic        csn, wen, ready;
    int unsigned r, ready_pct;

    n_edges = 0;
    bus.CSN = 1'b1; bus.WEN = 1'b1; bus.BE = 4'h0; bus.ADDR = 12'h0; bus.DI = 32'h0; bus.TX_READY = 1'b0;
    apply_reset("rst0");

    // Single push, then drain
    wr(12'hFF0, 32'hDEADBEEF, 4'hF, 1'b0);
    check("push1_valid", 32'(bus.TX_VALID), 32'h1);
    check("push1_cnt",   32'(FIFO_CNT),     32'h1);
    check("push1_data",  bus.TX_DATA,       32'hDEADBEEF);
    idle(1'b1);
    check("pop1_cnt",    32'(FIFO_CNT),     32'h0);

    // A partial-byte write to TXDATA is ignored
    wr(12'hFF0, 32'h12345678, 4'h7, 1'b0);
    check("partial_cnt", 32'(FIFO_CNT), 32'h0);

    // Overfill: the ninth word is dropped and sets OVF
    for (int i = 0; i < 9; i++) wr(12'hFF0, 32'h1000 + 32'(i), 4'hF, 1'b0);
    check("fill_cnt", 32'(FIFO_CNT), 32'h8);
    rd(12'hFF4, 1'b0);
    check("status_ovf", bus.DOUT, 32'h0000_0806);
    for (int i = 0; i < 8; i++) begin
      check("drain_data", bus.TX_DATA, 32'h1000 + 32'(i));
      idle(1'b1);
    end
    check("drain_empty", 32'(bus.TX_VALID), 32'h0);

    // Flush clears OVF; a push concurrent with a pop while full is accepted
    wr(12'hFF4, 32'h1, 4'h1, 1'b0);
    for (int i = 0; i < 8; i++) wr(12'hFF0, 32'h2000 + 32'(i), 4'hF, 1'b0);
    wr(12'hFF0, 32'hAAAA5555, 4'hF, 1'b1);
    check("full_pushpop_cnt", 32'(FIFO_CNT), 32'h8);
    rd(12'hFF4, 1'b0);
    check("status_full", bus.DOUT, 32'h0000_0802);
    // Flush coincident with a pop leaves the FIFO empty
    wr(12'hFF4, 32'h1, 4'h1, 1'b1);
    check("flush_pop_cnt", 32'(FIFO_CNT), 32'h0);

    // CYCLE wrap
    wr(12'hFF8, 32'hFFFFFFFE, 4'hF, 1'b0);
    idle(1'b0);
    rd(12'hFF8, 1'b0);
`ifdef MMIO_CYCLE_EN
    check("cycle_rd1", bus.DOUT, 32'hFFFFFFFF);
`else
    check("cycle_rd1", bus.DOUT, 32'h0);
`endif
    rd(12'hFF8, 1'b0);
    check("cycle_rd2", bus.DOUT, 32'h0);
    wr(12'hFF8, 32'h5A000000, 4'h8, 1'b0);
    rd(12'hFF8, 1'b0);

    // Writes outside the window or deselected have no effect
    wr(12'hEF0, 32'h11111111, 4'hF, 1'b0);
    step(1'b1, 1'b0, 4'hF, 12'hFF0, 32'h22222222, 1'b0);
    check("nohit_cnt", 32'(FIFO_CNT), 32'h0);

    // HALT is sticky
    wr(12'hFFC, 32'h1, 4'h1, 1'b0);
    check("halt_set", 32'(HALT), 32'h1);
    idle(1'b0);
    rd(12'hFFC, 1'b0);
    check("halt_rd",  bus.DOUT,     32'h1);
    check("halt_hit", 32'(bus.HIT), 32'h1);
    rd(12'h100, 1'b0);
    check("miss_hit", 32'(bus.HIT), 32'h0);

    // Mid-operation reset with three queued words
    for (int i = 0; i < 3; i++) wr(12'hFF0, 32'h3000 + 32'(i), 4'hF, 1'b0);
    rd(12'hFF4, 1'b0);
    check("pre_rst_status", bus.DOUT, 32'h0000_0300);
    #2;
    apply_reset("rst_mid");
    idle(1'b1);
    check("post_rst_cnt", 32'(FIFO_CNT), 32'h0);

    // Randomized traffic with drain pressure varying by phase
    ready_pct = 50;
    for (int i = 0; i < 800; i++) begin
      if (i % 100 == 0) ready_pct = $urandom_range(90, 5);
      r = $urandom_range(99);
      off = (r < 50) ? 2'd0 : (r < 72) ? 2'd1 : (r < 94) ? 2'd2 : 2'd3;
      a = {BASE, off, 2'($urandom)};
      if ($urandom_range(9) == 0) a[11:4] = 8'($urandom_range(254));
      csn = ($urandom_range(9) == 0);
      wen = 1'($urandom_range(1));
      be  = ($urandom_range(4) == 0) ? 4'($urandom) : 4'hF;
      di  = $urandom;
      if (off == 2'd1) di[0] = ($urandom_range(5) == 0);
      if (off == 2'd3) di[0] = ($urandom_range(29) == 0);
      ready = ($urandom_range(99) < ready_pct);
      step(csn, wen, be, a, di, ready);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
Memory-mapped I/O responder on the core's D-memory bus. It sits beside the data SP_SRAM and answers accesses that fall inside a 16-byte window. It exposes four registers: TX data push, status/flush, cycle counter and halt. It drains pushed words through a valid/ready stream towards the bench or a downstream transmitter. Its HALT output replaces the bench-side halt detection.

Parameters:
BASE_ADDR, 8'hFF, value compared against ADDR[11:4] to select the window (default window 0xFF0-0xFFF)
FIFO_DEPTH, 8, TX FIFO entries; power of two, 2..64
CNT_W, 4, FIFO count width; must equal log2(FIFO_DEPTH)+1

Ports:
CLK  input  1  clock, all state on rising edge
RST  input  1  asynchronous active-high reset
CSN  input  1  bus chip select, active low
WEN  input  1  bus write enable, active low (1 = read)
BE  input  4  byte enables, BE[i] covers DI[8i+7:8i]
ADDR  input  12  byte address; ADDR[1:0] ignored
DI  input  32  write data from core
DOUT  output  32  read data, valid the cycle after the read
HIT  output  1  registered: previous-cycle access hit the window; the bus mux selects DOUT over SRAM data when high
TX_VALID  output  1  FIFO head valid
TX_DATA  output  32  FIFO head word
TX_READY  input  1  consumer accepts head when TX_VALID & TX_READY
HALT  output  1  sticky halt request
FIFO_CNT  output  CNT_W  current FIFO occupancy

Behaviour:
- Reset (async, RST=1): DOUT=0, HIT=0, TX_VALID=0, TX_DATA=0, HALT=0, FIFO_CNT=0. Pointers, OVF and the cycle counter are cleared. Reset asserted mid-transfer discards FIFO contents; no partial handshake survives.
- Access: sel = ~CSN & (ADDR[11:4]==BASE_ADDR). Write = sel & ~WEN. Read = sel & WEN.
- Read latency is 1 cycle, matching SP_SRAM. DOUT and HIT are registered from the read. DOUT holds its value and HIT drops to 0 on cycles without a read.
- Register map (offset ADDR[3:2]):
  0x0 TXDATA. A write with BE==4'b1111 pushes DI into the FIFO; a partial-BE write is ignored. A read returns 0.
  0x4 STATUS. A read returns {16'b0, (8-CNT_W)'b0 ++ FIFO_CNT, 5'b0, OVF, full, empty}. A write with BE[0] & DI[0] flushes the FIFO and clears OVF.
  0x8 CYCLE. Free-running 32-bit counter, +1 every cycle, wraps 0xFFFFFFFF->0. A read returns the value at the read edge. A write loads the counter byte-wise per BE; the loaded value is visible next cycle, and the increment is suppressed on the write cycle.
  0xC HALT. A write with BE[0] & DI[0] sets HALT. HALT is sticky until reset. A read returns {31'b0, HALT}.
- FIFO: circular buffer with pointers wrapping mod FIFO_DEPTH. TX_VALID = (cnt!=0). TX_DATA is the head entry, combinational from storage.
- Pop = TX_VALID & TX_READY.
- Push is accepted if cnt<FIFO_DEPTH, or if cnt==FIFO_DEPTH and pop occurs in the same cycle; the count is then unchanged. A push that is otherwise made while full is dropped and sets OVF (sticky).
- Push on empty: TX_VALID rises the next cycle. There is no same-cycle bypass.
- Flush coincident with pop: the pop handshake completes (data was presented), and the FIFO is empty the next cycle.
- Writes outside the window, or with CSN=1, have no effect. HALT does not block bus or FIFO activity.

Optional Feature:
MMIO_CYCLE_EN
- Defined: the CYCLE register is implemented as above.
- Undefined: no counter flops; CYCLE reads return 32'h0 and writes are ignored. All other behaviour is identical.

Test Plan:
- Assert RST mid-operation with 3 words queued -> all outputs 0 asynchronously; FIFO_CNT=0 after release.
- Write 0xDEADBEEF to 0xFF0 (BE=1111), TX_READY=0 -> TX_VALID=1 and FIFO_CNT=1 the next cycle. Raise TX_READY -> TX_DATA=0xDEADBEEF is transferred and FIFO_CNT=0.
- Push 9 words with TX_READY=0, depth 8 -> FIFO_CNT=8; STATUS read returns 0x0000_0806 (OVF=1, full=1). The 9th word is never output.
- With FIFO full, push concurrently with pop -> push accepted, FIFO_CNT stays 8, OVF stays 0.
- Write CYCLE=0xFFFFFFFE, then read twice back-to-back -> DOUT=0xFFFFFFFF then 0x00000000 (with MMIO_CYCLE_EN); 0 and 0 without it.
- Write 0x1 to 0xFFC -> HALT=1 the next cycle and remains 1. A read of 0xFFC returns 1 with HIT=1. A read of 0x100 gives HIT=0.
